sha256_kh_fetch: RTL and testbench
==================================

Name: sha256_kh_fetch

Overview:
- Sits directly downstream of the memory manager that copies the SHA-256 constant table from EEPROM into the 128K RAM.
- After INIT_COMPLETE, reads the 8 initial hash words (RAM words 64..71) into a 256-bit register.
- Then serves round-constant requests: given round index t, returns K[t] from RAM word t.
- Sole RAM read master once init completes; feeds the compression core.

Parameters:
- K_BASE, 0, RAM word address of K[0].
- H_BASE, 64, RAM word address of H0.
- RD_LAT, 1, cycles from RAM_CE_N/RAM_OE_N low (registered) to RAM_DATA valid; legal range 1..4.
- ADDR_W, 15, RAM word address width.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- INIT_COMPLETE  input  1  memory manager finished loading RAM.
- H_READY  output  1  H_OUT valid and fetch block ready for K requests.
- H_OUT  output  256  H0..H7; H0 in [255:224], H7 in [31:0].
- K_REQ  input  1  request K[K_IDX]; sampled only when K_RDY=1.
- K_IDX  input  6  round index 0..63.
- K_RDY  output  1  block can accept a K request this cycle.
- K_VALID  output  1  one-cycle pulse; K_WORD valid.
- K_WORD  output  32  fetched constant; held until next K_VALID.
- RAM_ADDR  output  ADDR_W  RAM word address, registered.
- RAM_CE_N  output  1  RAM chip enable, active low, registered.
- RAM_OE_N  output  1  RAM output enable, active low, registered.
- RAM_WE_N  output  1  tied 1; this block never writes.
- RAM_DATA  input  32  RAM read data.

Behaviour:
- Reset values (async, RST_N low):
  - H_READY=0, H_OUT=0, K_RDY=0, K_VALID=0, K_WORD=0.
  - RAM_ADDR=0, RAM_CE_N=1, RAM_OE_N=1.
  - FSM=IDLE, word counter=0, latency counter=0.
- FSM states: IDLE, H_ISSUE, H_WAIT, H_CAPT, SERVE, K_WAIT, K_CAPT.
- IDLE:
  - Wait for INIT_COMPLETE=1 sampled at a rising edge, then go to H_ISSUE.
  - INIT_COMPLETE is a level; a later drop is ignored once left IDLE.
- H_ISSUE:
  - RAM_ADDR<=H_BASE+cnt; CE_N/OE_N<=0; latency counter<=RD_LAT-1.
  - Go to H_WAIT, or directly to H_CAPT when RD_LAT=1.
- H_WAIT: decrement counter; at 0 go to H_CAPT.
- H_CAPT:
  - Capture RAM_DATA into word cnt of H_OUT; CE_N/OE_N<=1.
  - cnt==7: H_READY<=1, K_RDY<=1, go to SERVE. Otherwise cnt+1, go to H_ISSUE.
  - Total H load: 8*(RD_LAT+1) cycles from leaving IDLE.
- SERVE:
  - K_RDY=1. On K_REQ=1: K_RDY<=0, RAM_ADDR<=K_BASE+K_IDX (zero-extended), CE_N/OE_N<=0, go to K_WAIT (or K_CAPT when RD_LAT=1).
- K_WAIT: same countdown as H_WAIT.
- K_CAPT:
  - K_WORD<=RAM_DATA, K_VALID<=1 for one cycle, CE_N/OE_N<=1, K_RDY<=1, back to SERVE.
  - Request accepted at edge N → K_VALID high after edge N+RD_LAT+1.
- K_REQ while K_RDY=0 (including before H_READY): ignored, not queued.
- K_IDX is sampled only at the accepting edge; later changes have no effect.
- H_READY, once set, stays 1 until reset.
- Reset mid-fetch:
  - All outputs return to reset values immediately; RAM_CE_N deasserts asynchronously.
  - After RST_N rises, the full H load is redone after INIT_COMPLETE.
- Address arithmetic is modulo 2^ADDR_W.

Optional Feature:
- Macro: SHA256_KPREFETCH_EN.
- Enabled:
  - After each K_CAPT, the block fetches K[(t+1) mod 64] into a prefetch buffer with a tag. Index 63 wraps to 0.
  - A request whose K_IDX matches a valid tag returns with K_VALID after edge N+1 and triggers the next prefetch.
  - A mismatch discards the buffer and performs a normal fetch.
  - K_RDY is low while a prefetch is in flight.
  - Buffer is invalidated on reset.
- Disabled: no prefetch; every request takes RD_LAT+1 cycles.

Test Plan:
- RD_LAT=1; RAM words 64..71 = 6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19; pulse INIT_COMPLETE → H_READY rises 16 cycles later; H_OUT[255:224]=6a09e667, H_OUT[31:0]=5be0cd19.
- After H_READY, request K_IDX=0 with RAM[0]=428a2f98 → RAM_ADDR=0, K_VALID one cycle at N+2, K_WORD=428a2f98; K_IDX=63 (RAM[63]=c67178f2) → K_WORD=c67178f2.
- RD_LAT=3: K request → K_VALID exactly 4 cycles after acceptance; RAM_CE_N low for 3 cycles.
- K_REQ held high before INIT_COMPLETE, and again on the cycle after acceptance → no RAM access and no K_VALID for the ignored cycles; exactly one K_VALID per accepted request.
- Assert RST_N=0 during the H load at word 4 → H_OUT=0, H_READY=0, RAM_CE_N=1 immediately; release reset and re-raise INIT_COMPLETE → full 8-word reload is correct.
- SHA256_KPREFETCH_EN: sequential requests t=0..63 then 0 → after the first, each request returns K_VALID at N+1; the wrap from 63 to 0 hits the buffer; a request for t=10 after t=3 misses and takes RD_LAT+1 cycles.

Source files
------------

// File: rtl/sha256_kh_fetch.sv
// sha256_kh_fetch: after INIT_COMPLETE loads H0..H7 from RAM, then serves K[t] reads.
// Optional next-index K prefetch buffer is built when SHA256_KPREFETCH_EN is defined.
module sha256_kh_fetch #(
  parameter int unsigned K_BASE = 0,
  parameter int unsigned H_BASE = 64,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned ADDR_W = 15
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              INIT_COMPLETE,
  output logic              H_READY,
  output logic [255:0]      H_OUT,
  input  logic              K_REQ,
  input  logic [5:0]        K_IDX,
  output logic              K_RDY,
  output logic              K_VALID,
  output logic [31:0]       K_WORD,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_CE_N,
  output logic              RAM_OE_N,
  output logic              RAM_WE_N,
  input  logic [31:0]       RAM_DATA
);

  localparam int unsigned      LAT_W    = 3;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT - 1);
  localparam bit               LAT_ONE  = (RD_LAT == 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_H_ISSUE,
    S_H_WAIT,
    S_H_CAPT,
    S_SERVE,
    S_K_WAIT,
    S_K_CAPT,
    S_PF_WAIT,
    S_PF_CAPT
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [255:0]        h_q, h_d;
  logic                h_ready_q, h_ready_d;
  logic                k_rdy_q, k_rdy_d;
  logic                k_valid_q, k_valid_d;
  logic [31:0]         k_word_q, k_word_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                vpend_q, vpend_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                ce_n_q, ce_n_d;
`ifdef SHA256_KPREFETCH_EN
  logic [5:0]          kidx_q, kidx_d;
  logic [5:0]          pf_tag_q, pf_tag_d;
  logic                pf_vld_q, pf_vld_d;
  logic [31:0]         pf_buf_q, pf_buf_d;
`endif

  assign H_READY  = h_ready_q;
  assign H_OUT    = h_q;
  assign K_RDY    = k_rdy_q;
  assign K_VALID  = k_valid_q;
  assign K_WORD   = k_word_q;
  assign RAM_ADDR = addr_q;
  assign RAM_CE_N = ce_n_q;
  assign RAM_OE_N = ce_n_q;
  assign RAM_WE_N = 1'b1;

  // Next-state and datapath; the returned word passes through rdata_q one cycle before K_VALID.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    h_d       = h_q;
    h_ready_d = h_ready_q;
    k_rdy_d   = k_rdy_q;
    rdata_d   = rdata_q;
    vpend_d   = 1'b0;
    addr_d    = addr_q;
    ce_n_d    = ce_n_q;
    k_valid_d = vpend_q;
    k_word_d  = vpend_q ? rdata_q : k_word_q;
`ifdef SHA256_KPREFETCH_EN
    kidx_d    = kidx_q;
    pf_tag_d  = pf_tag_q;
    pf_vld_d  = pf_vld_q;
    pf_buf_d  = pf_buf_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (INIT_COMPLETE) state_d = S_H_ISSUE;
      end
      S_H_ISSUE: begin
        addr_d  = ADDR_W'(H_BASE) + ADDR_W'(cnt_q);
        ce_n_d  = 1'b0;
        lat_d   = LAT_INIT;
        state_d = LAT_ONE ? S_H_CAPT : S_H_WAIT;
      end
      S_H_WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q <= LAT_W'(1)) state_d = S_H_CAPT;
      end
      S_H_CAPT: begin
        for (int unsigned w = 0; w < 8; w++) begin
          if (cnt_q == 3'(w)) h_d[(7 - w) * 32 +: 32] = RAM_DATA;
        end
        ce_n_d = 1'b1;
        if (cnt_q == 3'd7) begin
          cnt_d     = 3'd0;
          h_ready_d = 1'b1;
          k_rdy_d   = 1'b1;
          state_d   = S_SERVE;
        end else begin
          cnt_d   = 3'(cnt_q + 3'd1);
          state_d = S_H_ISSUE;
        end
      end
      S_SERVE: begin
        if (K_REQ) begin
          k_rdy_d = 1'b0;
          ce_n_d  = 1'b0;
          lat_d   = LAT_INIT;
`ifdef SHA256_KPREFETCH_EN
          pf_vld_d = 1'b0;
          if (pf_vld_q && (pf_tag_q == K_IDX)) begin
            // Hit: return the buffered word and immediately fetch the following index.
            rdata_d = pf_buf_q;
            vpend_d = 1'b1;
            kidx_d  = 6'(K_IDX + 6'd1);
            addr_d  = ADDR_W'(K_BASE) + ADDR_W'(6'(K_IDX + 6'd1));
            state_d = LAT_ONE ? S_PF_CAPT : S_PF_WAIT;
          end else begin
            kidx_d  = K_IDX;
            addr_d  = ADDR_W'(K_BASE) + ADDR_W'(K_IDX);
            state_d = LAT_ONE ? S_K_CAPT : S_K_WAIT;
          end
`else
          addr_d  = ADDR_W'(K_BASE) + ADDR_W'(K_IDX);
          state_d = LAT_ONE ? S_K_CAPT : S_K_WAIT;
`endif
        end
      end
      S_K_WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q <= LAT_W'(1)) state_d = S_K_CAPT;
      end
      S_K_CAPT: begin
        rdata_d = RAM_DATA;
        vpend_d = 1'b1;
`ifdef SHA256_KPREFETCH_EN
        // Keep the RAM enabled and move straight on to the next index.
        kidx_d  = 6'(kidx_q + 6'd1);
        addr_d  = ADDR_W'(K_BASE) + ADDR_W'(6'(kidx_q + 6'd1));
        lat_d   = LAT_INIT;
        state_d = LAT_ONE ? S_PF_CAPT : S_PF_WAIT;
`else
        ce_n_d  = 1'b1;
        k_rdy_d = 1'b1;
        state_d = S_SERVE;
`endif
      end
`ifdef SHA256_KPREFETCH_EN
      S_PF_WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q <= LAT_W'(1)) state_d = S_PF_CAPT;
      end
      S_PF_CAPT: begin
        pf_buf_d = RAM_DATA;
        pf_tag_d = kidx_q;
        pf_vld_d = 1'b1;
        ce_n_d   = 1'b1;
        k_rdy_d  = 1'b1;
        state_d  = S_SERVE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      lat_q     <= '0;
      h_q       <= '0;
      h_ready_q <= 1'b0;
      k_rdy_q   <= 1'b0;
      k_valid_q <= 1'b0;
      k_word_q  <= '0;
      rdata_q   <= '0;
      vpend_q   <= 1'b0;
      addr_q    <= '0;
      ce_n_q    <= 1'b1;
`ifdef SHA256_KPREFETCH_EN
      kidx_q    <= '0;
      pf_tag_q  <= '0;
      pf_vld_q  <= 1'b0;
      pf_buf_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
      h_q       <= h_d;
      h_ready_q <= h_ready_d;
      k_rdy_q   <= k_rdy_d;
      k_valid_q <= k_valid_d;
      k_word_q  <= k_word_d;
      rdata_q   <= rdata_d;
      vpend_q   <= vpend_d;
      addr_q    <= addr_d;
      ce_n_q    <= ce_n_d;
`ifdef SHA256_KPREFETCH_EN
      kidx_q    <= kidx_d;
      pf_tag_q  <= pf_tag_d;
      pf_vld_q  <= pf_vld_d;
      pf_buf_q  <= pf_buf_d;
`endif
    end
  end

endmodule

// File: tb/tb_sha256_kh_fetch.sv
// Bench for sha256_kh_fetch: two instances (RD_LAT 1 and 3) with RAM models, directed plus random K requests.
module tb_sha256_kh_fetch;

  localparam int unsigned NI = 2;
  localparam int unsigned AW = 15;
`ifdef SHA256_KPREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [NI-1:0]          init, k_req, h_ready, k_rdy, k_valid, ce_n, oe_n, we_n;
  logic [NI-1:0][5:0]     k_idx;
  logic [NI-1:0][255:0]   h_out;
  logic [NI-1:0][31:0]    k_word, ram_data;
  logic [NI-1:0][AW-1:0]  ram_addr;
  logic [31:0]            mem [0:127];
  logic [31:0]            p_a, p_b;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: prefetch expectation and last returned word per instance.
  bit          pf_valid  [NI];
  logic [5:0]  pf_next   [NI];
  logic [31:0] last_word [NI];

  always #5 clk = ~clk;

  sha256_kh_fetch #(.K_BASE(0), .H_BASE(64), .RD_LAT(1), .ADDR_W(AW)) u_dut_l1 (
    .CLK(clk), .RST_N(rst_n), .INIT_COMPLETE(init[0]), .H_READY(h_ready[0]), .H_OUT(h_out[0]),
    .K_REQ(k_req[0]), .K_IDX(k_idx[0]), .K_RDY(k_rdy[0]), .K_VALID(k_valid[0]), .K_WORD(k_word[0]),
    .RAM_ADDR(ram_addr[0]), .RAM_CE_N(ce_n[0]), .RAM_OE_N(oe_n[0]), .RAM_WE_N(we_n[0]),
    .RAM_DATA(ram_data[0])
  );

  sha256_kh_fetch #(.K_BASE(0), .H_BASE(64), .RD_LAT(3), .ADDR_W(AW)) u_dut_l3 (
    .CLK(clk), .RST_N(rst_n), .INIT_COMPLETE(init[1]), .H_READY(h_ready[1]), .H_OUT(h_out[1]),
    .K_REQ(k_req[1]), .K_IDX(k_idx[1]), .K_RDY(k_rdy[1]), .K_VALID(k_valid[1]), .K_WORD(k_word[1]),
    .RAM_ADDR(ram_addr[1]), .RAM_CE_N(ce_n[1]), .RAM_OE_N(oe_n[1]), .RAM_WE_N(we_n[1]),
    .RAM_DATA(ram_data[1])
  );

  // RAM models: data of the registered address is valid RD_LAT edges later; junk when disabled.
  always @(posedge clk) begin
    p_a <= (!ce_n[1] && !oe_n[1]) ? mem[ram_addr[1][6:0]] : 32'hBAD0_BAD0;
    p_b <= p_a;
  end

  always_comb begin
    ram_data[0] = (!ce_n[0] && !oe_n[0]) ? mem[ram_addr[0][6:0]] : 32'hDEAD_BEEF;
    ram_data[1] = p_b;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] h_exp();
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[(7 - w) * 32 +: 32] = mem[64 + w];
    return r;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic clear_model();
    for (int n = 0; n < NI; n++) begin
      pf_valid[n]  = 1'b0;
      pf_next[n]   = '0;
      last_word[n] = '0;
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    init  = '0;
    k_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
  endtask

  task automatic check_reset_values(input int i);
    chk("rst_h_ready", h_ready[i], 1'b0);
    chk("rst_h_out", h_out[i], '0);
    chk("rst_k_rdy", k_rdy[i], 1'b0);
    chk("rst_k_valid", k_valid[i], 1'b0);
    chk("rst_k_word", k_word[i], '0);
    chk("rst_ram_addr", ram_addr[i], '0);
    chk("rst_ce_n", ce_n[i], 1'b1);
    chk("rst_oe_n", oe_n[i], 1'b1);
    chk("rst_we_n", we_n[i], 1'b1);
  endtask

  // Requests before INIT_COMPLETE must be ignored entirely.
  task automatic pre_init(input int i);
    bit saw_ce = 0;
    bit saw_v  = 0;
    bit saw_r  = 0;
    k_req[i] = 1'b1;
    k_idx[i] = 6'd5;
    repeat (10) begin
      @(negedge clk);
      if (!ce_n[i]) saw_ce = 1;
      if (k_valid[i]) saw_v = 1;
      if (k_rdy[i]) saw_r = 1;
    end
    k_req[i] = 1'b0;
    chk("pre_init_ram_access", saw_ce, 1'b0);
    chk("pre_init_k_valid", saw_v, 1'b0);
    chk("pre_init_k_rdy", saw_r, 1'b0);
  endtask

  // Full H load: H_READY must rise exactly 8*(lat+1) edges after INIT is sampled.
  task automatic h_load(input int i, input int lat);
    int t = 8 * (lat + 1);
    init[i] = 1'b1;
    repeat (t) @(negedge clk);
    chk("h_ready_early", h_ready[i], 1'b0);
    @(negedge clk);
    init[i] = 1'b0;
    chk("h_ready", h_ready[i], 1'b1);
    chk("h_out", h_out[i], h_exp());
    chk("h_out_h0", h_out[i][255:224], mem[64]);
    chk("h_out_h7", h_out[i][31:0], mem[71]);
    chk("k_rdy_after_h", k_rdy[i], 1'b1);
  endtask

  // Reset while word 4 is being read, then verify a complete reload with fresh H words.
  task automatic h_load_reset(input int i, input int lat);
    logic [255:0] part;
    init[i] = 1'b1;
    repeat (4 * (lat + 1) + 2) @(negedge clk);
    part = h_exp();
    chk("mid_load_ce_n", ce_n[i], 1'b0);
    chk("mid_load_h_words0_3", h_out[i][255:128], part[255:128]);
    chk("mid_load_h_ready", h_ready[i], 1'b0);
    #1;
    rst_n   = 1'b0;
    init[i] = 1'b0;
    #1;
    chk("async_rst_h_out", h_out[i], '0);
    chk("async_rst_h_ready", h_ready[i], 1'b0);
    chk("async_rst_ce_n", ce_n[i], 1'b1);
    chk("async_rst_oe_n", oe_n[i], 1'b1);
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle_ce_n", ce_n[i], 1'b1);
    for (int w = 0; w < 8; w++) mem[64 + w] = $urandom;
    h_load(i, lat);
  endtask

  // One K request; optionally hold K_REQ one more cycle with another index, which must be ignored.
  task automatic do_req(input int i, input int lat, input logic [5:0] idx, input bit hold, input logic [5:0] xidx);
    int guard = 0;
    bit hit;
    bit early = 0;
    bit extra = 0;
    int exp_lat;
    int exp_ce;
    int ce_cnt = 0;
    logic [5:0]  nxt;
    logic [31:0] exp_w;
    while (k_rdy[i] !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("k_rdy_wait", k_rdy[i], 1'b1);
    chk("k_word_held", k_word[i], last_word[i]);
    hit     = PF && pf_valid[i] && (idx == pf_next[i]);
    exp_lat = hit ? 1 : lat + 1;
    if (!PF)     exp_ce = lat;
    else if (hit) exp_ce = imin(2, lat);
    else          exp_ce = imin(lat + 2, 2 * lat);
    nxt   = idx + 6'd1;
    exp_w = mem[7'(idx)];
    k_req[i] = 1'b1;
    k_idx[i] = idx;
    @(negedge clk);
    if (hold) k_idx[i] = xidx;
    else      k_req[i] = 1'b0;
    chk("k_rdy_after_accept", k_rdy[i], 1'b0);
    chk("ram_addr", ram_addr[i], hit ? AW'(nxt) : AW'(idx));
    chk("ram_ce_n_after_accept", ce_n[i], 1'b0);
    if (k_valid[i]) early = 1;
    if (!ce_n[i]) ce_cnt++;
    for (int j = 1; j <= exp_lat; j++) begin
      @(negedge clk);
      k_req[i] = 1'b0;
      if (j < exp_lat && k_valid[i]) early = 1;
      if (!ce_n[i]) ce_cnt++;
    end
    chk("k_valid_early", early, 1'b0);
    chk("k_valid", k_valid[i], 1'b1);
    chk("k_word", k_word[i], exp_w);
    chk("ce_low_cycles", ce_cnt, exp_ce);
    repeat (lat + 3) begin
      @(negedge clk);
      if (k_valid[i]) extra = 1;
    end
    chk("k_valid_single_pulse", extra, 1'b0);
    last_word[i] = exp_w;
    pf_valid[i]  = 1'b1;
    pf_next[i]   = nxt;
  endtask

  task automatic run_suite(input int i, input int lat);
    reset_pulse();
    pre_init(i);
    for (int w = 0; w < 8; w++) mem[64 + w] = 32'h0;
    mem[64] = 32'h6a09e667; mem[65] = 32'hbb67ae85; mem[66] = 32'h3c6ef372; mem[67] = 32'ha54ff53a;
    mem[68] = 32'h510e527f; mem[69] = 32'h9b05688c; mem[70] = 32'h1f83d9ab; mem[71] = 32'h5be0cd19;
    h_load(i, lat);
    do_req(i, lat, 6'd0, 1'b1, 6'd7);
    do_req(i, lat, 6'd63, 1'b1, 6'd1);
    for (int r = 0; r < 4; r++)
      do_req(i, lat, 6'($urandom_range(63, 0)), 1'($urandom_range(1, 0)), 6'($urandom_range(63, 0)));
    reset_pulse();
    h_load_reset(i, lat);
    for (int r = 0; r < 4; r++)
      do_req(i, lat, 6'($urandom_range(63, 0)), 1'($urandom_range(1, 0)), 6'($urandom_range(63, 0)));
    for (int t = 0; t < 64; t++) do_req(i, lat, 6'(t), 1'b0, 6'd0);
    do_req(i, lat, 6'd0, 1'b0, 6'd0);
    do_req(i, lat, 6'd3, 1'b0, 6'd0);
    do_req(i, lat, 6'd10, 1'b1, 6'd11);
    chk("h_ready_sticky", h_ready[i], 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    init  = '0;
    k_req = '0;
    k_idx = '0;
    clear_model();
    for (int a = 0; a < 128; a++) mem[a] = $urandom;
    mem[0]  = 32'h428a2f98;
    mem[63] = 32'hc67178f2;
    repeat (3) @(negedge clk);
    check_reset_values(0);
    check_reset_values(1);
    rst_n = 1'b1;
    run_suite(0, 1);
    run_suite(1, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
